// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use interlock, memory-wait stall with watchdog,
// branch-redirect flushes, and saturating stall/flush statistics.
package hazard_unit_pkg;
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_IMM = 2'd3
  } writebackType_;
endpackage

module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          decodeValid,
  input  logic [4:0]    decodeRegister1,
  input  logic [4:0]    decodeRegister2,
  input  logic          decodeUses1,
  input  logic          decodeUses2,
  input  logic          decodeExecuteValid,
  input  logic [4:0]    decodeExecuteDestinationRegister,
  input  writebackType_ decodeExecuteWritebackType,
  input  logic          branchRedirect,
  input  logic          memoryRequest,
  input  logic          memoryReady,
  output logic          fetchStall,
  output logic          decodeStall,
  output logic          executeStall,
  output logic          executeBubble,
  output logic          flushFetchDecode,
  output logic          flushDecodeExecute,
  output logic          memoryWritebackBubble,
  output logic          memoryTimeout,
  output logic [31:0]   stallCycles,
  output logic [31:0]   flushCount
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  wait_counter_reg, wait_counter_next;
  logic        timeout_reg, timeout_next;
  logic [31:0] stall_cycles_reg, stall_cycles_next;
  logic [31:0] flush_count_reg, flush_count_next;

  logic load_use;
  logic mem_wait;
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = decodeUses1 && (decodeRegister1 == decodeExecuteDestinationRegister);
  assign rs2_hit  = decodeUses2 && (decodeRegister2 == decodeExecuteDestinationRegister);
  // x0 is hardwired to zero, so a load targeting it never produces a real dependency.
  assign load_use = decodeValid && decodeExecuteValid &&
                    (decodeExecuteWritebackType == WB_MEM) &&
                    (decodeExecuteDestinationRegister != 5'd0) &&
                    (rs1_hit || rs2_hit);

  assign mem_wait = ((state_reg == RUN) && memoryRequest && !memoryReady) ||
                    ((state_reg == MEM_WAIT) && !memoryReady);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:      if (memoryRequest && !memoryReady) state_next = MEM_WAIT;
      MEM_WAIT: if (memoryReady) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  // A redirect seen while waiting is simply masked; it takes effect on the ready
  // cycle only if execute is still presenting it then.
  always_comb begin
    fetchStall            = 1'b0;
    decodeStall           = 1'b0;
    executeStall          = 1'b0;
    executeBubble         = 1'b0;
    flushFetchDecode      = 1'b0;
    flushDecodeExecute    = 1'b0;
    memoryWritebackBubble = 1'b0;
    if (mem_wait) begin
      fetchStall            = 1'b1;
      decodeStall           = 1'b1;
      executeStall          = 1'b1;
      memoryWritebackBubble = 1'b1;
    end else if (branchRedirect) begin
      flushFetchDecode   = 1'b1;
      flushDecodeExecute = 1'b1;
    end else if (load_use) begin
      fetchStall    = 1'b1;
      decodeStall   = 1'b1;
      executeBubble = 1'b1;
    end
  end

  always_comb begin
    wait_counter_next = 8'd0;
    if (state_reg == MEM_WAIT)
      wait_counter_next = (wait_counter_reg == 8'hFF) ? 8'hFF : wait_counter_reg + 8'd1;
    // Sets on the edge where the counter reaches 255 with the access still pending.
    timeout_next = timeout_reg ||
                   ((state_reg == MEM_WAIT) && !memoryReady && (wait_counter_reg >= 8'd254));
    stall_cycles_next = stall_cycles_reg;
    if (fetchStall && (stall_cycles_reg != 32'hFFFF_FFFF))
      stall_cycles_next = stall_cycles_reg + 32'd1;
    flush_count_next = flush_count_reg;
    if (flushFetchDecode && (flush_count_reg != 32'hFFFF_FFFF))
      flush_count_next = flush_count_reg + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= RUN;
      wait_counter_reg <= 8'd0;
      timeout_reg      <= 1'b0;
      stall_cycles_reg <= 32'd0;
      flush_count_reg  <= 32'd0;
    end else begin
      state_reg        <= state_next;
      wait_counter_reg <= wait_counter_next;
      timeout_reg      <= timeout_next;
      stall_cycles_reg <= stall_cycles_next;
      flush_count_reg  <= flush_count_next;
    end
  end

  assign memoryTimeout = timeout_reg;
  assign stallCycles   = stall_cycles_reg;
  assign flushCount    = flush_count_reg;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: literal expectations per scenario plus a
// per-cycle comparison against a rule-level behavioural model.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic          clock = 1'b0;
  logic          reset;
  logic          decodeValid;
  logic [4:0]    decodeRegister1, decodeRegister2;
  logic          decodeUses1, decodeUses2;
  logic          decodeExecuteValid;
  logic [4:0]    decodeExecuteDestinationRegister;
  writebackType_ decodeExecuteWritebackType;
  logic          branchRedirect, memoryRequest, memoryReady;
  logic          fetchStall, decodeStall, executeStall, executeBubble;
  logic          flushFetchDecode, flushDecodeExecute, memoryWritebackBubble, memoryTimeout;
  logic [31:0]   stallCycles, flushCount;

  int checks = 0;
  int errors = 0;

  hazard_unit dut (
    .clock(clock), .reset(reset),
    .decodeValid(decodeValid),
    .decodeRegister1(decodeRegister1), .decodeRegister2(decodeRegister2),
    .decodeUses1(decodeUses1), .decodeUses2(decodeUses2),
    .decodeExecuteValid(decodeExecuteValid),
    .decodeExecuteDestinationRegister(decodeExecuteDestinationRegister),
    .decodeExecuteWritebackType(decodeExecuteWritebackType),
    .branchRedirect(branchRedirect), .memoryRequest(memoryRequest), .memoryReady(memoryReady),
    .fetchStall(fetchStall), .decodeStall(decodeStall), .executeStall(executeStall),
    .executeBubble(executeBubble), .flushFetchDecode(flushFetchDecode),
    .flushDecodeExecute(flushDecodeExecute), .memoryWritebackBubble(memoryWritebackBubble),
    .memoryTimeout(memoryTimeout), .stallCycles(stallCycles), .flushCount(flushCount)
  );

  initial forever #5 clock = ~clock;

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Control vector order: {fetchStall, decodeStall, executeStall, executeBubble,
  //                        flushFetchDecode, flushDecodeExecute, memoryWritebackBubble}
  bit     armed = 0;
  bit     outstanding = 0;   // a memory access was left unfinished last cycle
  int     wait_run = 0;      // consecutive cycles spent waiting on memory
  bit     m_timeout = 0;
  longint m_stalls = 0;
  longint m_flushes = 0;

  function automatic logic [6:0] model_ctrl();
    bit waiting, hazard;
    waiting = !memoryReady && (outstanding || memoryRequest);
    hazard  = decodeValid && decodeExecuteValid && decodeExecuteWritebackType == WB_MEM &&
              decodeExecuteDestinationRegister != 0 &&
              ((decodeUses1 && decodeRegister1 == decodeExecuteDestinationRegister) ||
               (decodeUses2 && decodeRegister2 == decodeExecuteDestinationRegister));
    if (waiting)             return 7'b1110001;
    else if (branchRedirect) return 7'b0000110;
    else if (hazard)         return 7'b1101000;
    else                     return 7'b0000000;
  endfunction

  always @(posedge clock) begin
    logic [6:0] c;
    c = model_ctrl();
    if (reset) begin
      armed = 1; outstanding = 0; wait_run = 0; m_timeout = 0; m_stalls = 0; m_flushes = 0;
    end else if (armed) begin
      if (c[6] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (c[2] && m_flushes < 64'hFFFF_FFFF) m_flushes++;
      outstanding = !memoryReady && (outstanding || memoryRequest);
      wait_run = outstanding ? wait_run + 1 : 0;
      if (wait_run >= 256) m_timeout = 1;
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      expect_eq("model_ctrl",
                {fetchStall, decodeStall, executeStall, executeBubble,
                 flushFetchDecode, flushDecodeExecute, memoryWritebackBubble},
                {25'd0, model_ctrl()});
      expect_eq("model_timeout", {31'd0, memoryTimeout}, {31'd0, m_timeout});
      expect_eq("model_stallCycles", stallCycles, m_stalls[31:0]);
      expect_eq("model_flushCount", flushCount, m_flushes[31:0]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    decodeValid = 0; decodeRegister1 = 0; decodeRegister2 = 0;
    decodeUses1 = 0; decodeUses2 = 0; decodeExecuteValid = 0;
    decodeExecuteDestinationRegister = 0; decodeExecuteWritebackType = WB_ALU;
    branchRedirect = 0; memoryRequest = 0; memoryReady = 0;
  endtask

  task automatic load_use(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input writebackType_ wb);
    decodeValid = 1; decodeRegister1 = rs1; decodeUses1 = u1;
    decodeRegister2 = rs2; decodeUses2 = u2;
    decodeExecuteValid = 1; decodeExecuteDestinationRegister = rd;
    decodeExecuteWritebackType = wb;
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    settle();
    expect_eq("reset_stallCycles", stallCycles, 0);
    expect_eq("reset_flushCount", flushCount, 0);
    expect_eq("reset_timeout", {31'd0, memoryTimeout}, 0);
    expect_eq("reset_idle_ctrl", {31'd0, fetchStall | flushFetchDecode | executeBubble}, 0);

    // Load x5 in execute, decode reads x5 through rs1.
    load_use(5'd5, 1, 5'd0, 0, 5'd5, WB_MEM);
    settle();
    expect_eq("lu_stall", {29'd0, fetchStall, decodeStall, executeBubble}, 3'b111);
    expect_eq("lu_execStall", {31'd0, executeStall}, 0);
    tick(); idle(); settle();
    expect_eq("lu_count", stallCycles, 1);
    expect_eq("lu_released", {31'd0, fetchStall}, 0);

    // No hazard: rd=x0, rs1 not used, or a non-load producer.
    load_use(5'd0, 1, 5'd0, 0, 5'd0, WB_MEM); settle();
    expect_eq("x0_nostall", {31'd0, fetchStall}, 0);
    load_use(5'd5, 0, 5'd0, 0, 5'd5, WB_MEM); settle();
    expect_eq("nouse_nostall", {31'd0, fetchStall}, 0);
    load_use(5'd5, 1, 5'd0, 0, 5'd5, WB_ALU); settle();
    expect_eq("alu_nostall", {31'd0, fetchStall}, 0);
    tick(); idle(); settle();
    expect_eq("nostall_count", stallCycles, 1);

    // Hazard through rs2.
    load_use(5'd3, 1, 5'd7, 1, 5'd7, WB_MEM); settle();
    expect_eq("rs2_bubble", {31'd0, executeBubble}, 1);
    tick(); idle(); settle();
    expect_eq("rs2_count", stallCycles, 2);

    // Memory access ready after three waiting cycles.
    memoryRequest = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      expect_eq("mem_wait_ctrl",
                {28'd0, fetchStall, decodeStall, executeStall, memoryWritebackBubble}, 4'b1111);
      tick();
    end
    memoryReady = 1; settle();
    expect_eq("mem_ready_ctrl", {30'd0, fetchStall, memoryWritebackBubble}, 0);
    tick(); idle(); settle();
    expect_eq("mem_count", stallCycles, 5);

    // Redirect wins over load-use.
    load_use(5'd5, 1, 5'd0, 0, 5'd5, WB_MEM);
    branchRedirect = 1; settle();
    expect_eq("redir_flush", {30'd0, flushFetchDecode, flushDecodeExecute}, 2'b11);
    expect_eq("redir_nobubble", {30'd0, executeBubble, fetchStall}, 0);
    tick(); idle(); settle();
    expect_eq("redir_count", flushCount, 1);
    expect_eq("redir_stalls", stallCycles, 5);

    // Redirect during a memory wait is held off until the ready cycle.
    memoryRequest = 1; branchRedirect = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      expect_eq("defer_noflush", {30'd0, flushFetchDecode, flushDecodeExecute}, 0);
      expect_eq("defer_stall", {31'd0, fetchStall}, 1);
      tick();
    end
    memoryReady = 1; settle();
    expect_eq("defer_flush", {30'd0, flushFetchDecode, flushDecodeExecute}, 2'b11);
    tick(); idle(); settle();
    expect_eq("defer_count", flushCount, 2);
    expect_eq("defer_stalls", stallCycles, 7);

    // Watchdog: memory never ready for 300 cycles.
    memoryRequest = 1;
    for (int i = 1; i <= 300; i++) begin
      settle();
      if (i == 256) expect_eq("timeout_before", {31'd0, memoryTimeout}, 0);
      if (i == 257) expect_eq("timeout_set", {31'd0, memoryTimeout}, 1);
      tick();
    end
    settle();
    expect_eq("timeout_sticky", {31'd0, memoryTimeout}, 1);

    // Reset while in MEM_WAIT.
    memoryRequest = 0; reset = 1; settle();
    expect_eq("rst_midwait_stall", {31'd0, fetchStall}, 1);
    tick(); reset = 0; idle(); settle();
    expect_eq("rst_run_nostall", {31'd0, fetchStall}, 0);
    expect_eq("rst_timeout", {31'd0, memoryTimeout}, 0);
    expect_eq("rst_stalls", stallCycles, 0);
    expect_eq("rst_flushes", flushCount, 0);
    memoryRequest = 1; memoryReady = 1; settle();
    expect_eq("fast_mem_nostall", {31'd0, fetchStall}, 0);
    tick(); idle(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
